menu_stream_tx: RTL
===================

MENU_STREAM_TX -- requirements
Module: menu_stream_tx

Interface
REQ-001 SHALL have parameter NAME_LEN, default 16, meaning the maximum number of characters per menu line.
REQ-002 SHALL have parameter MAX_LINES, default 30, meaning the number of rows on screen, including title row 0.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-005 SHALL have port start, input, 1, one-cycle request to stream one full menu.
REQ-006 SHALL have port num_entries, input, 5, the number of entry lines after the title (row 0), sampled when start is accepted.
REQ-007 SHALL have port rom_addr, output, 9, name ROM address {line[4:0], char[3:0]}.
REQ-008 SHALL have port rom_data, input, 8, name ROM byte, valid exactly one cycle after rom_addr.
REQ-009 SHALL have port tx_data, output, 8, the byte offered to the text display receiver.
REQ-010 SHALL have port tx_valid, output, 1, asserted when tx_data holds a byte to transfer.
REQ-011 SHALL have port tx_ready, input, 1, receiver ready; a transfer occurs on a rising clk with tx_valid and tx_ready both high.
REQ-012 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse after the final byte transfers.

Function
REQ-014 SHALL accept start only in IDLE; start while busy is ignored.
REQ-015 SHALL clamp the effective line count L = min(num_entries, MAX_LINES-1), latched at acceptance.
REQ-016 SHALL emit bytes in order:
- 0x83 (hide cursor), then 0x80 (home);
- for line = 0..L: that line's characters;
- 0x0D after each line except the last (line L);
- 0x81 (cursor to row 1), then 0x82 (show cursor).
REQ-017 SHALL end a line's characters at the first rom_data of 0x00 (NUL not sent) or after NAME_LEN characters, whichever comes first.
REQ-018 SHALL send a ROM byte with bit7 set as 0x3F, so the receiver never treats name bytes as commands.
REQ-019 SHALL send ROM byte 0x0D as 0x20 so that names cannot cause a line break.
REQ-020 SHALL use states IDLE, HIDE, HOME, FETCH, WAIT, CHAR, EOL, ROW1, SHOW, DONE:
- IDLE->HIDE on start.
- HIDE->HOME, HOME->FETCH, EOL->FETCH, ROW1->SHOW and SHOW->DONE each on transfer.
- FETCH->WAIT unconditionally; FETCH drives rom_addr.
- WAIT->CHAR when rom_data is nonzero; on NUL, WAIT->EOL if line<L, else WAIT->ROW1.
- CHAR: on transfer, go to FETCH with char+1; if char = NAME_LEN-1, go to EOL or ROW1 as in WAIT.
- DONE->IDLE after one cycle.
REQ-021 SHALL advance line by 1 and reset char to 0 when EOL transfers.
REQ-022 SHALL drive tx_valid high only in HIDE, HOME, CHAR, EOL, ROW1 and SHOW.
REQ-023 SHALL hold tx_data constant while tx_valid is high and tx_ready is low.
REQ-024 SHALL never deassert tx_valid before the transfer occurs.
REQ-025 SHALL drive tx_data, tx_valid and done from registers, with no combinational path from tx_ready.
REQ-026 SHALL take at most 3 cycles per character when tx_ready is held high: FETCH, WAIT, CHAR.
REQ-027 SHALL stream the title only when num_entries = 0: 0x83, 0x80, title chars, 0x81, 0x82.
REQ-028 SHALL assert done for exactly one cycle in DONE; busy SHALL be low in IDLE and high in all other states.

Reset
REQ-029 SHALL, when reset_n is low at a clock edge, enter IDLE with tx_valid=0, tx_data=0x00, busy=0, done=0, rom_addr=0, and line/char counters = 0.
REQ-030 SHALL abort a stream on reset mid-operation with no further bytes; a start after reset releases SHALL begin again with 0x83.

Verification
REQ-031 SHALL cover: ROM title "AB"+NUL, entry1 "C"+NUL, num_entries=1, tx_ready=1 -> bytes 83,80,41,42,0D,43,81,82, then a done pulse.
REQ-032 SHALL cover: a 16-char line with no NUL, NAME_LEN=16 -> exactly 16 chars, then 0x0D, with no 17th ROM read.
REQ-033 SHALL cover: ROM bytes 0x9A and 0x0D in a name -> sent as 0x3F and 0x20.
REQ-034 SHALL cover: tx_ready toggled randomly -> the byte sequence matches REQ-031, and tx_data is stable while stalled.
REQ-035 SHALL cover: num_entries=31 -> 30 lines sent and exactly 29 0x0D bytes; a start pulse mid-stream is ignored.
REQ-036 SHALL cover: reset_n low during CHAR -> tx_valid=0 next cycle; after a new start, the first byte is 0x83.

Source files
------------

// File: rtl/menu_stream_tx_if.sv
// Byte stream from the menu streamer to a text display receiver.
// Master: tx_data, tx_valid out, tx_ready in. Slave: the reverse.
interface menu_stream_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/menu_stream_tx.sv
// Streams a menu from a name ROM to a text display as a byte stream.
// Ports: clk, reset_n (sync, active low), start, num_entries, rom_addr/rom_data, tx (master), busy, done.
module menu_stream_tx #(
  parameter int NAME_LEN  = 16,
  parameter int MAX_LINES = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       num_entries,
  output logic [8:0]       rom_addr,
  input  logic [7:0]       rom_data,
  menu_stream_tx_if.master tx,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] LMAX  = 5'(MAX_LINES - 1);
  localparam logic [3:0] CLAST = 4'(NAME_LEN - 1);

  typedef enum logic [3:0] {
    IDLE,
    HIDE,
    HOME,
    FETCH,
    WAIT,
    CHAR,
    EOL,
    ROW1,
    SHOW,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] line_q, line_d;
  logic [3:0] char_q, char_d;
  logic [4:0] last_q, last_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       done_q, done_d;
  logic [8:0] rom_addr_q, rom_addr_d;

  logic xfer;
  logic more_lines;

  // Name bytes are sanitised so they can never act as display commands.
  function automatic logic [7:0] map_byte(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[7]) begin
      r = 8'h3F;
    end else if (b == 8'h0D) begin
      r = 8'h20;
    end
    return r;
  endfunction

  assign xfer       = tx_valid_q & tx.tx_ready;
  assign more_lines = (line_q < last_q);

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    char_d     = char_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    rom_addr_d = rom_addr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HIDE;
          line_d     = '0;
          char_d     = '0;
          last_d     = (num_entries > LMAX) ? LMAX : num_entries;
          tx_data_d  = 8'h83;
          tx_valid_d = 1'b1;
        end
      end
      HIDE: begin
        if (xfer) begin
          state_d   = HOME;
          tx_data_d = 8'h80;
        end
      end
      HOME: begin
        if (xfer) begin
          state_d    = FETCH;
          tx_valid_d = 1'b0;
          rom_addr_d = {line_q, char_q};
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        tx_valid_d = 1'b1;
        if (rom_data != 8'h00) begin
          state_d   = CHAR;
          tx_data_d = map_byte(rom_data);
        end else if (more_lines) begin
          state_d   = EOL;
          tx_data_d = 8'h0D;
        end else begin
          state_d   = ROW1;
          tx_data_d = 8'h81;
        end
      end
      CHAR: begin
        if (xfer) begin
          if (char_q == CLAST) begin
            // Full-width name: end the line without another ROM read.
            if (more_lines) begin
              state_d   = EOL;
              tx_data_d = 8'h0D;
            end else begin
              state_d   = ROW1;
              tx_data_d = 8'h81;
            end
          end else begin
            state_d    = FETCH;
            tx_valid_d = 1'b0;
            char_d     = char_q + 4'd1;
            rom_addr_d = {line_q, char_q + 4'd1};
          end
        end
      end
      EOL: begin
        if (xfer) begin
          state_d    = FETCH;
          tx_valid_d = 1'b0;
          line_d     = line_q + 5'd1;
          char_d     = '0;
          rom_addr_d = {line_q + 5'd1, 4'd0};
        end
      end
      ROW1: begin
        if (xfer) begin
          state_d   = SHOW;
          tx_data_d = 8'h82;
        end
      end
      SHOW: begin
        if (xfer) begin
          state_d    = DONE;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      char_q     <= '0;
      last_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      char_q     <= char_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign rom_addr    = rom_addr_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule
